// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF-stage fetch/alignment block.
package fetch_pkg;

  typedef logic [15:0] halfword_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } align_state_e;

  localparam logic [1:0]  OPC_NONC = 2'b11;
  localparam logic [31:0] INS_NOP  = 32'h0000_0013;

endpackage

// File: rtl/fetch_align_ctrl_hw_queue.sv
// Halfword FIFO: push 0/1/2, pop 0/1/2, synchronous clear; head two entries
// are visible combinationally.
module hw_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic [1:0]                 push_cnt_i,
  input  halfword_t                  push_hw0_i,
  input  halfword_t                  push_hw1_i,
  input  logic [1:0]                 pop_cnt_i,
  output halfword_t                  head0_o,
  output halfword_t                  head1_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [$clog2(DEPTH+1)-1:0] free_o
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned PW1 = PW + 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);

  halfword_t     mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Pointer advance with wrap; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW1-1:0] s;
    s = {1'b0, p} + PW1'(n);
    if (s >= PW1'(DEPTH)) s = s - PW1'(DEPTH);
    return s[PW-1:0];
  endfunction

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      rd_d  = ptr_add(rd_q, pop_cnt_i);
      wr_d  = ptr_add(wr_q, push_cnt_i);
      cnt_d = cnt_q + CW'(push_cnt_i) - CW'(pop_cnt_i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_i) begin
      if (push_cnt_i != 2'd0) mem_q[wr_q] <= push_hw0_i;
      if (push_cnt_i == 2'd2) mem_q[ptr_add(wr_q, 2'd1)] <= push_hw1_i;
    end
  end

  assign head0_o = mem_q[rd_q];
  assign head1_o = mem_q[ptr_add(rd_q, 2'd1)];
  assign count_o = cnt_q;
  assign free_o  = CW'(DEPTH) - cnt_q;

endmodule

// File: rtl/fetch_align_ctrl.sv
// IF-stage fetch sequencer and 16/32-bit instruction aligner.
// Define FETCH_ALIGN_RVC_EN to enable compressed (16-bit) instruction support.
module fetch_align_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned QDEPTH          = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fetch_req_o,
  output logic [31:0] fetch_addr_o,
  input  logic        fetch_gnt_i,
  input  logic        fetch_rvalid_i,
  input  logic [31:0] fetch_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        ins_valid_o,
  input  logic        ins_ready_i,
  output logic [31:0] ins_o,
  output logic [31:0] ins_pc_o,
  output logic        ins_is_c_o,
  output logic        misalign_o
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CW = $clog2(QDEPTH + 1);

  align_state_e state_q, state_d;

  logic          active_q;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [31:0]   head_pc_q, head_pc_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] drop_q, drop_d;
  logic          skip_low_q, skip_low_d;
  logic          misalign_q, misalign_d;

  logic          q_clr;
  logic [1:0]    q_push_cnt, q_pop_cnt;
  halfword_t     q_hw0, q_hw1, q_head0, q_head1;
  logic [CW-1:0] q_count, q_free;

  logic          head_is_c, head_ok;
  logic [OW-1:0] live_outst;
  logic          gnt, rsp, pop;
  logic          unused_pc0;

  assign unused_pc0 = redirect_pc_i[0];

  hw_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (q_clr),
    .push_cnt_i (q_push_cnt),
    .push_hw0_i (q_hw0),
    .push_hw1_i (q_hw1),
    .pop_cnt_i  (q_pop_cnt),
    .head0_o    (q_head0),
    .head1_o    (q_head1),
    .count_o    (q_count),
    .free_o     (q_free)
  );

`ifdef FETCH_ALIGN_RVC_EN
  assign head_is_c = (q_head0[1:0] != OPC_NONC);
`else
  assign head_is_c = 1'b0;
`endif
  assign head_ok = head_is_c ? (q_count >= CW'(1)) : (q_count >= CW'(2));

  // Issue only when every live in-flight word plus this one has two free slots.
  always_comb begin
    live_outst   = outst_q - drop_q;
    fetch_req_o  = active_q && !redirect_i
                && (32'(q_free) >= 32'd2 * (32'(live_outst) + 32'd1))
                && (32'(outst_q) < MAX_OUTSTANDING);
    fetch_addr_o = fetch_addr_q;
    ins_valid_o  = head_ok && !redirect_i;
    ins_o        = INS_NOP;
    if (head_ok) ins_o = head_is_c ? {16'h0000, q_head0} : {q_head1, q_head0};
    ins_pc_o     = head_pc_q;
    ins_is_c_o   = head_is_c && head_ok;
    misalign_o   = misalign_q;
  end

  always_comb begin
    gnt          = fetch_req_o && fetch_gnt_i;
    rsp          = fetch_rvalid_i && (outst_q != '0);
    pop          = ins_valid_o && ins_ready_i;
    fetch_addr_d = fetch_addr_q;
    head_pc_d    = head_pc_q;
    outst_d      = outst_q + OW'(gnt) - OW'(rsp);
    drop_d       = drop_q;
    skip_low_d   = skip_low_q;
    misalign_d   = misalign_q;
    q_clr        = 1'b0;
    q_push_cnt   = 2'd0;
    q_pop_cnt    = 2'd0;
    q_hw0        = fetch_rdata_i[15:0];
    q_hw1        = fetch_rdata_i[31:16];
    if (redirect_i) begin
      q_clr        = 1'b1;
      drop_d       = outst_q - OW'(rsp);
      fetch_addr_d = {redirect_pc_i[31:2], 2'b00};
`ifdef FETCH_ALIGN_RVC_EN
      head_pc_d    = {redirect_pc_i[31:1], 1'b0};
      skip_low_d   = redirect_pc_i[1];
`else
      head_pc_d    = {redirect_pc_i[31:2], 2'b00};
      skip_low_d   = 1'b0;
      if (redirect_pc_i[1]) misalign_d = 1'b1;
`endif
    end else begin
      if (gnt) fetch_addr_d = fetch_addr_q + 32'd4;
      if (rsp) begin
        if (drop_q != '0) begin
          drop_d = drop_q - OW'(1);
        end else if (skip_low_q) begin
          q_push_cnt = 2'd1;
          q_hw0      = fetch_rdata_i[31:16];
          skip_low_d = 1'b0;
        end else begin
          q_push_cnt = 2'd2;
        end
      end
      if (pop) begin
        q_pop_cnt = head_is_c ? 2'd1 : 2'd2;
        head_pc_d = head_pc_q + (head_is_c ? 32'd2 : 32'd4);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (redirect_i && (drop_d != '0)) state_d = DRAIN;
      DRAIN:   if (drop_d == '0) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q     <= 1'b0;
      fetch_addr_q <= RESET_PC;
      head_pc_q    <= RESET_PC;
      outst_q      <= '0;
      drop_q       <= '0;
      skip_low_q   <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      active_q     <= 1'b1;
      fetch_addr_q <= fetch_addr_d;
      head_pc_q    <= head_pc_d;
      outst_q      <= outst_d;
      drop_q       <= drop_d;
      skip_low_q   <= skip_low_d;
      misalign_q   <= misalign_d;
    end
  end

endmodule

// File: tb/tb_fetch_align_ctrl.sv
// Directed bench for fetch_align_ctrl with an in-order, variable-latency memory model.
module tb_fetch_align_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req_o;
  logic [31:0] fetch_addr_o;
  logic        fetch_gnt_i;
  logic        fetch_rvalid_i;
  logic [31:0] fetch_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        ins_valid_o;
  logic        ins_ready_i;
  logic [31:0] ins_o;
  logic [31:0] ins_pc_o;
  logic        ins_is_c_o;
  logic        misalign_o;

`ifdef FETCH_ALIGN_RVC_EN
  localparam logic [31:0] TGT      = 32'h0000_0206;
  localparam logic [31:0] STALL_PC = 32'h0000_020C;
  localparam logic        MIS_END  = 1'b0;
`else
  localparam logic [31:0] TGT      = 32'h0000_0500;
  localparam logic [31:0] STALL_PC = 32'h0000_0504;
  localparam logic        MIS_END  = 1'b1;
`endif

  fetch_align_ctrl #(
    .RESET_PC        (32'h0000_0100),
    .QDEPTH          (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_req_o    (fetch_req_o),
    .fetch_addr_o   (fetch_addr_o),
    .fetch_gnt_i    (fetch_gnt_i),
    .fetch_rvalid_i (fetch_rvalid_i),
    .fetch_rdata_i  (fetch_rdata_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .ins_valid_o    (ins_valid_o),
    .ins_ready_i    (ins_ready_i),
    .ins_o          (ins_o),
    .ins_pc_o       (ins_pc_o),
    .ins_is_c_o     (ins_is_c_o),
    .misalign_o     (misalign_o)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  int unsigned lat   = 1;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] pend_addr [$];
  int unsigned pend_due  [$];
  logic [31:0] gnt_log   [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0000_0013;
  endfunction

  function automatic logic [31:0] log_at(input int unsigned i);
    if (i < gnt_log.size()) return gnt_log[i];
    return 32'hFFFF_FFFF;
  endfunction

  // Memory: grants every request, answers in order after lat cycles.
  initial begin
    fetch_gnt_i    = 1'b0;
    fetch_rvalid_i = 1'b0;
    fetch_rdata_i  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
        fetch_rvalid_i = 1'b1;
        fetch_rdata_i  = rd_mem(pend_addr[0]);
      end else begin
        fetch_rvalid_i = 1'b0;
        fetch_rdata_i  = '0;
      end
      fetch_gnt_i = 1'b1;
      @(negedge clk);
      if (fetch_rvalid_i) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (fetch_req_o && fetch_gnt_i) begin
        pend_addr.push_back(fetch_addr_o);
        pend_due.push_back(cyc + lat);
        gnt_log.push_back(fetch_addr_o);
      end
    end
  end

  task automatic expect_ins(input string tag, input logic [31:0] ins,
                            input logic [31:0] pc, input logic c);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (ins_valid_o) begin
        seen = 1'b1;
        check({tag, "_ins"}, ins_o, ins);
        check({tag, "_pc"}, ins_pc_o, pc);
        check({tag, "_c"}, 32'(ins_is_c_o), 32'(c));
        ins_ready_i = 1'b1;
        @(posedge clk);
        #1 ins_ready_i = 1'b0;
      end
    end
    if (!seen) check({tag, "_timeout"}, 32'(ins_valid_o), 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] pc, input bit clr);
    @(posedge clk);
    #1;
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    if (clr) gnt_log.delete();
    @(negedge clk);
    check("redir_valid", 32'(ins_valid_o), 32'd0);
    check("redir_req", 32'(fetch_req_o), 32'd0);
    @(posedge clk);
    #1 redirect_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst           = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    ins_ready_i   = 1'b0;
    mem[32'h100]  = 32'h0041_0513;
    mem[32'h104]  = 32'h4505_4501;
    mem[32'h108]  = 32'h0000_0001;
    mem[32'h10C]  = 32'h0513_4501;
    mem[32'h110]  = 32'h0000_0041;
    mem[32'h204]  = 32'h4509_0000;
    mem[32'h208]  = 32'h0041_0513;
    mem[32'h300]  = 32'h00A0_0093;
    mem[32'h400]  = 32'hDEAD_BEEF;
    mem[32'h404]  = 32'hDEAD_BEEF;
    mem[32'h500]  = 32'h1234_5678;

    repeat (2) @(posedge clk);
    #2;
    check("rst_req", 32'(fetch_req_o), 32'd0);
    check("rst_valid", 32'(ins_valid_o), 32'd0);
    check("rst_mis", 32'(misalign_o), 32'd0);
    check("rst_addr", fetch_addr_o, 32'h100);
    @(negedge clk);
    #2 rst = 1'b1;

    expect_ins("w0", 32'h0041_0513, 32'h100, 1'b0);
    check("gnt0", log_at(0), 32'h100);
    check("gnt1", log_at(1), 32'h104);

`ifdef FETCH_ALIGN_RVC_EN
    expect_ins("c0", 32'h0000_4501, 32'h104, 1'b1);
    expect_ins("c1", 32'h0000_4505, 32'h106, 1'b1);
    expect_ins("c2", 32'h0000_0001, 32'h108, 1'b1);
    expect_ins("c3", 32'h0000_0000, 32'h10A, 1'b1);
    expect_ins("c4", 32'h0000_4501, 32'h10C, 1'b1);
    expect_ins("x5", 32'h0041_0513, 32'h10E, 1'b0);
    expect_ins("c6", 32'h0000_0000, 32'h112, 1'b1);
`else
    expect_ins("n0", 32'h4505_4501, 32'h104, 1'b0);
    expect_ins("n1", 32'h0000_0001, 32'h108, 1'b0);
    expect_ins("n2", 32'h0513_4501, 32'h10C, 1'b0);
    expect_ins("n3", 32'h0000_0041, 32'h110, 1'b0);
    check("mis_pre", 32'(misalign_o), 32'd0);
    do_redirect(32'h302, 1'b1);
    expect_ins("mis", 32'h00A0_0093, 32'h300, 1'b0);
    check("mis_gnt", log_at(0), 32'h300);
    check("mis_set", 32'(misalign_o), 32'd1);
`endif

    // Two stale fetches in flight when the second redirect lands.
    repeat (10) @(posedge clk);
    lat = 4;
    do_redirect(32'h400, 1'b1);
    @(posedge clk);
    do_redirect(TGT, 1'b0);
`ifdef FETCH_ALIGN_RVC_EN
    expect_ins("tgt0", 32'h0000_4509, 32'h206, 1'b1);
    expect_ins("tgt1", 32'h0041_0513, 32'h208, 1'b0);
`else
    expect_ins("tgt0", 32'h1234_5678, 32'h500, 1'b0);
`endif
    check("drop_gnt0", log_at(0), 32'h400);
    check("drop_gnt1", log_at(1), 32'h404);
    check("drop_gnt2", log_at(2), {TGT[31:2], 2'b00});

    lat = 1;
    repeat (12) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_req", 32'(fetch_req_o), 32'd0);
      check("stall_valid", 32'(ins_valid_o), 32'd1);
      check("stall_ins", ins_o, 32'h0000_0013);
      check("stall_pc", ins_pc_o, STALL_PC);
    end
    expect_ins("res0", 32'h0000_0013, STALL_PC, 1'b0);
    expect_ins("res1", 32'h0000_0013, STALL_PC + 32'd4, 1'b0);
    check("mis_end", 32'(misalign_o), 32'(MIS_END));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
